// File: rtl/calc_display_pkg.sv
// Shared types and constants for the result display path (state encoding, BCD width,
// active-low gfedcba seven-segment patterns).
package calc_display_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int BCD_W = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to active-low gfedcba segment encoder.
// Non-decimal codes fall back to all segments off.
module bcd_to_7seg
  import calc_display_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [6:0]       seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/result_display_decoder.sv
// Signed result -> sign + BCD digits via one-shift-per-cycle double dabble, with leading-zero
// blanking. Define RESULT_DISPLAY_SEVEN_SEG_EN to add the registered seg_out port.
module result_display_decoder
  import calc_display_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int NUM_DIGITS = 5
) (
  input  logic                        clk,
  input  logic                        nRST,
  input  logic [WIDTH-1:0]            result_in,
  input  logic                        result_valid,
  output logic                        busy,
  output logic                        done,
  output logic                        negative,
  output logic [BCD_W*NUM_DIGITS-1:0] bcd_digits,
  output logic [NUM_DIGITS-1:0]       digit_blank
`ifdef RESULT_DISPLAY_SEVEN_SEG_EN
  ,
  output logic [7*(NUM_DIGITS+1)-1:0] seg_out
`endif
);

  localparam int SW = BCD_W * NUM_DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t          state;
  logic            valid_q;
  logic            neg_next;
  logic [WIDTH-1:0] mag;
  logic [SW-1:0]   scratch;
  logic [SW-1:0]   adj;
  logic [CW-1:0]   cnt;
  logic [NUM_DIGITS-1:0] blank_next;

  wire rise = result_valid & ~valid_q;

  always_comb begin
    adj = scratch;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (scratch[BCD_W*i +: BCD_W] >= BCD_W'(5))
        adj[BCD_W*i +: BCD_W] = scratch[BCD_W*i +: BCD_W] + BCD_W'(3);
  end

  // Digit i blanks when it and every more-significant digit are zero; the ones digit never does.
  always_comb begin
    blank_next = '0;
    for (int i = 1; i < NUM_DIGITS; i++)
      blank_next[i] = ((scratch >> (BCD_W*i)) == '0);
  end

`ifdef RESULT_DISPLAY_SEVEN_SEG_EN
  logic [NUM_DIGITS-1:0][6:0] seg_dig;
  logic [7*(NUM_DIGITS+1)-1:0] seg_next;

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_seg
      bcd_to_7seg u_seg (.bcd(scratch[BCD_W*g +: BCD_W]), .seg(seg_dig[g]));
    end
  endgenerate

  always_comb begin
    seg_next = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      seg_next[7*i +: 7] = blank_next[i] ? SEG_BLANK : seg_dig[i];
    seg_next[7*NUM_DIGITS +: 7] = neg_next ? SEG_MINUS : SEG_BLANK;
  end
`endif

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      valid_q     <= 1'b0;
      neg_next    <= 1'b0;
      mag         <= '0;
      scratch     <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      negative    <= 1'b0;
      bcd_digits  <= '0;
      digit_blank <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
`ifdef RESULT_DISPLAY_SEVEN_SEG_EN
      seg_out     <= {{NUM_DIGITS{SEG_BLANK}}, SEG_0};
`endif
    end else begin
      valid_q <= result_valid;
      done    <= 1'b0;
      case (state)
        IDLE: if (rise) begin
          neg_next <= result_in[WIDTH-1];
          // Unsigned negate: the most negative input maps to its true magnitude.
          mag      <= result_in[WIDTH-1] ? (~result_in + WIDTH'(1)) : result_in;
          scratch  <= '0;
          cnt      <= '0;
          busy     <= 1'b1;
          state    <= SHIFT;
        end
        SHIFT: begin
          {scratch, mag} <= {adj[SW-2:0], mag, 1'b0};
          cnt            <= cnt + CW'(1);
          if (cnt == CW'(WIDTH-1)) state <= DONE;
        end
        DONE: begin
          bcd_digits  <= scratch;
          negative    <= neg_next;
          digit_blank <= blank_next;
`ifdef RESULT_DISPLAY_SEVEN_SEG_EN
          seg_out     <= seg_next;
`endif
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_display_decoder.sv
// Randomized self-checking bench for result_display_decoder against a decimal-arithmetic model.
module tb_result_display_decoder;

  localparam int WIDTH = 16;
  localparam int ND    = 5;

  logic          clk = 1'b0;
  logic          nRST = 1'b0;
  logic [15:0]   result_in = '0;
  logic          result_valid = 1'b0;
  logic          busy, done, negative;
  logic [19:0]   bcd_digits;
  logic [4:0]    digit_blank;
`ifdef RESULT_DISPLAY_SEVEN_SEG_EN
  logic [41:0]   seg_out;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [19:0] exp_bcd = '0;
  logic        exp_neg = 1'b0;
  logic [4:0]  exp_blank = 5'b11110;

  result_display_decoder #(.WIDTH(WIDTH), .NUM_DIGITS(ND)) dut (
    .clk(clk), .nRST(nRST), .result_in(result_in), .result_valid(result_valid),
    .busy(busy), .done(done), .negative(negative), .bcd_digits(bcd_digits),
    .digit_blank(digit_blank)
`ifdef RESULT_DISPLAY_SEVEN_SEG_EN
    , .seg_out(seg_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: decimal digits by division, blanking by magnitude comparison.
  function automatic logic [19:0] ref_bcd(input int a);
    logic [19:0] r = '0;
    int p = 1;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'((a / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] ref_blank(input int a);
    logic [4:0] b = '0;
    int p = 10;
    for (int i = 1; i < ND; i++) begin
      b[i] = (a < p);
      p = p * 10;
    end
    return b;
  endfunction

`ifdef RESULT_DISPLAY_SEVEN_SEG_EN
  function automatic logic [41:0] ref_seg(input logic [19:0] d, input logic [4:0] b, input logic n);
    logic [6:0] tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [41:0] s;
    for (int i = 0; i < ND; i++) s[7*i +: 7] = b[i] ? 7'h7F : tab[d[4*i +: 4]];
    s[41:35] = n ? 7'h3F : 7'h7F;
    return s;
  endfunction
`endif

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_neg"},   negative, 0);
    chk({tag, "_bcd"},   bcd_digits, 20'h00000);
    chk({tag, "_blank"}, digit_blank, 5'b11110);
`ifdef RESULT_DISPLAY_SEVEN_SEG_EN
    chk({tag, "_seg"},   seg_out, {{5{7'h7F}}, 7'h40});
`endif
    exp_bcd = '0; exp_neg = 1'b0; exp_blank = 5'b11110;
  endtask

  // Drive one conversion and check latency, output holding, the done pulse and the result.
  task automatic convert(input logic [15:0] v);
    int a, cyc;
    logic hold_ok, busy_ok;
    a = v[15] ? 65536 - int'(v) : int'(v);
    @(negedge clk);
    result_in = v; result_valid = 1'b1;
    cyc = 0; hold_ok = 1'b1; busy_ok = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      if (!done) begin
        if (bcd_digits !== exp_bcd || negative !== exp_neg || digit_blank !== exp_blank) hold_ok = 1'b0;
        if (busy !== 1'b1) busy_ok = 1'b0;
      end
    end while (!done && cyc < 40);
    // cyc counts edges starting with the trigger edge itself
    chk("latency", cyc - 1, 17);
    chk("hold", hold_ok, 1);
    chk("busy_during", busy_ok, 1);
    exp_bcd = ref_bcd(a); exp_neg = v[15]; exp_blank = ref_blank(a);
    chk("bcd", bcd_digits, exp_bcd);
    chk("neg", negative, exp_neg);
    chk("blank", digit_blank, exp_blank);
`ifdef RESULT_DISPLAY_SEVEN_SEG_EN
    chk("seg", seg_out, ref_seg(exp_bcd, exp_blank, exp_neg));
`endif
    chk("busy_end", busy, 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
    result_valid = 1'b0;
  endtask

  initial begin
    int cyc, ndone;
    logic [15:0] v;

    #12;
    chk_reset_vals("por");
    @(negedge clk); nRST = 1'b1;
    repeat (2) @(negedge clk);

    convert(16'd12345);
    convert(16'hFFF9);
    convert(16'h8000);
    convert(16'h7FFF);
    convert(16'd0);
    convert(16'd9);
    convert(16'd10);

    // Reset while idle with non-reset outputs on display
    convert(16'hFF85);
    @(negedge clk); nRST = 1'b0;
    #1 chk_reset_vals("idle_rst");
    @(negedge clk); nRST = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 20; k++) begin
      v = (k % 2) ? 16'($urandom) : 16'($urandom_range(0, 1200));
      if (k % 4 == 2) v = -v;
      convert(v);
    end

    // Re-raise during a conversion is ignored; holding high does not retrigger
    @(negedge clk);
    result_in = 16'd42; result_valid = 1'b1;
    repeat (5) @(negedge clk);
    result_valid = 1'b0; result_in = 16'd99;
    @(negedge clk);
    result_valid = 1'b1;
    cyc = 6; ndone = 0;
    while (!done && cyc < 40) begin @(negedge clk); cyc++; end
    chk("retrig_latency", cyc - 1, 17);
    chk("retrig_bcd", bcd_digits, 20'h00042);
    ndone = 0;
    repeat (50) begin @(negedge clk); if (done) ndone++; end
    chk("held_no_redone", ndone, 0);
    exp_bcd = 20'h00042; exp_neg = 1'b0; exp_blank = 5'b11100;
    chk("held_bcd", bcd_digits, exp_bcd);
    result_valid = 1'b0;
    @(negedge clk);

    // Reset mid-conversion aborts it
    result_in = 16'd500; result_valid = 1'b1;
    repeat (9) @(negedge clk);
    chk("abort_busy_pre", busy, 1);
    nRST = 1'b0;
    #1 chk_reset_vals("abort_rst");
    result_valid = 1'b0;
    @(negedge clk); nRST = 1'b1;
    ndone = 0;
    repeat (30) begin @(negedge clk); if (done || busy) ndone++; end
    chk("abort_no_done", ndone, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
